// File: rtl/mux_key_reg_pkg.sv
// Shared constants for the ysyx_22050039 general-purpose register file.
package ysyx_22050039_pkg;

    localparam int XLEN    = 64;
    localparam int NR_REG  = 32;
    localparam int REG_SEL = 5;
    localparam int X0_IDX  = 0;

endpackage

// File: rtl/mux_key_reg_if.sv
// Register-file access bundle: one write port, two read ports and the
// decoded write-enable vector.
interface mux_key_reg_if;
    import ysyx_22050039_pkg::*;

    logic               wen;
    logic [REG_SEL-1:0] rd;
    logic [XLEN-1:0]    wdata;
    logic [REG_SEL-1:0] rs1;
    logic [REG_SEL-1:0] rs2;
    logic [XLEN-1:0]    rdata1;
    logic [XLEN-1:0]    rdata2;
    logic [NR_REG-1:0]  wen_onehot;

    // The IDU/execute side drives indices and write data.
    modport master (
        output wen, rd, wdata, rs1, rs2,
        input  rdata1, rdata2, wen_onehot
    );

    // The register file consumes them and returns read data.
    modport slave (
        input  wen, rd, wdata, rs1, rs2,
        output rdata1, rdata2, wen_onehot
    );

endinterface

// File: rtl/mux_key_reg_muxkey.sv
// Keyed lookup mux: returns the data of the first {key, data} pair whose
// key matches, or zero when nothing matches. The first pair sits in the MSBs.
module ysyx_22050039_MuxKey #(
    parameter int NR_KEY   = 2,
    parameter int KEY_LEN  = 1,
    parameter int DATA_LEN = 1
) (
    input  logic [KEY_LEN-1:0]                   key_i,
    input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] lut_i,
    output logic [DATA_LEN-1:0]                  out_o
);

    localparam int PAIR_LEN = KEY_LEN + DATA_LEN;

    // Scan from the last pair to the first so the earliest match wins.
    always_comb begin
        out_o = '0;
        for (int j = NR_KEY - 1; j >= 0; j--) begin
            if (lut_i[(NR_KEY - j) * PAIR_LEN - 1 -: KEY_LEN] == key_i) begin
                out_o = lut_i[(NR_KEY - j) * PAIR_LEN - KEY_LEN - 1 -: DATA_LEN];
            end
        end
    end

endmodule

// File: rtl/mux_key_reg_reg.sv
// Enable register with asynchronous active-high reset to RESET_VAL.
module ysyx_22050039_Reg #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    input  logic             wen
);

    logic [WIDTH-1:0] data_q;

    // Reset wins immediately; otherwise load on a rising edge when enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= RESET_VAL;
        end else if (wen) begin
            data_q <= din;
        end
    end

    assign dout = data_q;

endmodule

// File: rtl/mux_key_reg.sv
// General-purpose register file: rd is decoded to a one-hot enable by a
// MuxKey, one Reg per architectural register, x0 hard-wired to zero,
// combinational reads with no write bypass.
module mux_key_reg
    import ysyx_22050039_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    mux_key_reg_if.slave  bus
);

    localparam int PAIR_LEN = REG_SEL + NR_REG;
    localparam int NR_IDX   = 2 ** REG_SEL;

    logic [NR_REG*PAIR_LEN-1:0] decodeLut;
    logic [NR_REG-1:0]          decodedHot;
    logic [NR_REG-1:0]          wenHot;
    logic [XLEN-1:0]            regVal    [NR_REG];
    logic [XLEN-1:0]            readTable [NR_IDX];

    // Lookup table: pair i maps index i to the one-hot word 1<<i, pair 0 in the MSBs.
    for (genvar i = 0; i < NR_REG; i++) begin : g_lut
        assign decodeLut[(NR_REG - i) * PAIR_LEN - 1 -: PAIR_LEN] =
            {REG_SEL'(i), NR_REG'(1) << i};
    end

    ysyx_22050039_MuxKey #(
        .NR_KEY   (NR_REG),
        .KEY_LEN  (REG_SEL),
        .DATA_LEN (NR_REG)
    ) u_decode (
        .key_i (bus.rd),
        .lut_i (decodeLut),
        .out_o (decodedHot)
    );

    assign wenHot         = bus.wen ? decodedHot : '0;
    assign bus.wen_onehot = wenHot;

    // x0 ignores its enable bit so writes to it are silently dropped.
    for (genvar i = 0; i < NR_REG; i++) begin : g_regs
        if (i == X0_IDX) begin : g_x0
            ysyx_22050039_Reg #(
                .WIDTH     (XLEN),
                .RESET_VAL ('0)
            ) u_reg (
                .clk  (clk),
                .rst  (rst),
                .din  (bus.wdata),
                .dout (regVal[i]),
                .wen  (1'b0)
            );
        end else begin : g_xn
            ysyx_22050039_Reg #(
                .WIDTH     (XLEN),
                .RESET_VAL (RESET_VAL)
            ) u_reg (
                .clk  (clk),
                .rst  (rst),
                .din  (bus.wdata),
                .dout (regVal[i]),
                .wen  (wenHot[i])
            );
        end
    end

    // Indices with no backing register read as zero.
    for (genvar i = 0; i < NR_IDX; i++) begin : g_read
        if (i < NR_REG) begin : g_real
            assign readTable[i] = regVal[i];
        end else begin : g_none
            assign readTable[i] = '0;
        end
    end

    assign bus.rdata1 = readTable[bus.rs1];
    assign bus.rdata2 = readTable[bus.rs2];

endmodule

// File: tb/tb_mux_key_reg.sv
// Self-checking bench for the register file: directed cases followed by a
// randomized phase, all checked against an array-based model of the
// architectural registers.
module tb_mux_key_reg;
    import ysyx_22050039_pkg::*;

    logic clk;
    logic rst;
    int   assertCount = 0;
    int   failCount   = 0;

    // Architectural view: x0 is never written, so it stays zero.
    logic [XLEN-1:0] model [NR_REG];

    mux_key_reg_if bus ();

    mux_key_reg dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison: counts it, and on mismatch counts and reports the failure.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Architectural read rule: index 0 is always zero, others return the model.
    function automatic logic [63:0] expectRead(input logic [REG_SEL-1:0] idx);
        return (idx == 0) ? 64'd0 : model[idx];
    endfunction

    task automatic clearModel();
        for (int i = 0; i < NR_REG; i++) model[i] = '0;
    endtask

    // Drive one cycle of traffic: check decode and old read data before the
    // edge, then the updated read data just after it.
    task automatic applyStimulus(input logic w, input logic [REG_SEL-1:0] r,
                                 input logic [XLEN-1:0] d,
                                 input logic [REG_SEL-1:0] a,
                                 input logic [REG_SEL-1:0] b,
                                 input string tag);
        bus.wen   = w;
        bus.rd    = r;
        bus.wdata = d;
        bus.rs1   = a;
        bus.rs2   = b;
        #1;
        checkOutput({tag, " onehot"}, 64'(bus.wen_onehot), w ? (64'd1 << r) : 64'd0);
        checkOutput({tag, " rdata1 pre"}, bus.rdata1, expectRead(a));
        checkOutput({tag, " rdata2 pre"}, bus.rdata2, expectRead(b));
        @(posedge clk);
        if (w && r != 0) model[r] = d;
        #1;
        checkOutput({tag, " rdata1 post"}, bus.rdata1, expectRead(a));
        checkOutput({tag, " rdata2 post"}, bus.rdata2, expectRead(b));
    endtask

    // Pulse reset mid-cycle and confirm the register reads zero before any edge.
    task automatic asyncResetPulse(input logic [REG_SEL-1:0] idx, input string tag);
        bus.wen = 1'b0;
        bus.rs1 = idx;
        #2;
        rst = 1'b1;
        #1;
        clearModel();
        checkOutput({tag, " rdata1"}, bus.rdata1, 64'd0);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [REG_SEL-1:0] idx;

        clearModel();
        rst       = 1'b0;
        bus.wen   = 1'b0;
        bus.rd    = '0;
        bus.wdata = '0;
        bus.rs1   = 5'd9;
        bus.rs2   = 5'd31;

        // Power-up reset.
        #1 rst = 1'b1;
        #1;
        checkOutput("reset rdata1", bus.rdata1, 64'd0);
        checkOutput("reset rdata2", bus.rdata2, 64'd0);
        checkOutput("reset onehot", 64'(bus.wen_onehot), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Async reset after a real write.
        applyStimulus(1'b1, 5'd5, 64'hDEAD, 5'd5, 5'd0, "x5 write");
        asyncResetPulse(5'd5, "async reset x5");

        // Basic write/read on both ports.
        applyStimulus(1'b1, 5'd10, 64'h0123_4567_89AB_CDEF, 5'd10, 5'd10, "x10 write");

        // x0 immutability.
        applyStimulus(1'b1, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd0, 5'd0, "x0 write");

        // Enable gating keeps x7 at its prior value.
        applyStimulus(1'b1, 5'd7, 64'h11, 5'd7, 5'd7, "x7 set");
        applyStimulus(1'b0, 5'd7, 64'h55, 5'd7, 5'd7, "x7 gated");

        // One-hot sweep with readback of rd*3.
        for (int r = 0; r < NR_REG; r++) begin
            applyStimulus(1'b1, REG_SEL'(r), 64'(r * 3), REG_SEL'(r), REG_SEL'(r), "sweep");
        end

        // Read-during-write returns the old value until the edge.
        applyStimulus(1'b1, 5'd3, 64'hA, 5'd3, 5'd3, "rdw first");
        applyStimulus(1'b1, 5'd3, 64'hB, 5'd3, 5'd3, "rdw second");

        // Randomized traffic with occasional mid-cycle resets.
        for (int n = 0; n < 200; n++) begin
            if (n % 50 == 49) begin
                idx = REG_SEL'($urandom_range(1, NR_REG - 1));
                asyncResetPulse(idx, "random reset");
            end
            applyStimulus($urandom_range(0, 3) != 0, REG_SEL'($urandom),
                          {$urandom, $urandom}, REG_SEL'($urandom),
                          REG_SEL'($urandom), "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertCount, failCount);
        $finish;
    end

endmodule
